// File: rtl/vga_scroll_sequencer.sv
// Frame-synchronous horizontal scroll sequencer for the VGA pattern datapath.
// Optional edge bounce between 0 and BOUNCE_MAX when VGA_SCROLL_BOUNCE_EN is defined.
module vga_scroll_sequencer #(
   parameter int   OFFSET_W   = 10,
   parameter int   SPEED_W    = 3,
   parameter int   FRAME_DIV  = 1,
   parameter logic VSYNC_POL  = 1'b0,
   parameter int   BOUNCE_MAX = 639
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                vsync_in,
   input  logic                run_en,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [7:0]          cmd_arg,
   output logic [OFFSET_W-1:0] scroll_x,
   output logic                frame_tick,
   output logic [1:0]          state
);

   // state | meaning
   // IDLE  | held, waiting for run_en at a frame boundary
   // RUN   | stepping scroll_x every FRAME_DIV frames
   // PAUSE | enabled but frozen by SET_PAUSE
   typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_PAUSE = 2'b10} state_t;

   localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(FRAME_DIV - 1);
   localparam logic [1:0] OP_SPEED = 2'b00, OP_DIR = 2'b01, OP_PAUSE = 2'b10, OP_LOAD = 2'b11;

   if (FRAME_DIV < 1 || BOUNCE_MAX >= 2 ** OFFSET_W) begin : g_bad_param
      $error("vga_scroll_sequencer: FRAME_DIV must be >=1 and BOUNCE_MAX must fit OFFSET_W");
   end

   state_t               state_q, state_d;
   logic                 vs_q, tick_q, tick_d;
   logic                 pending_q, pending_d;
   logic [1:0]           op_q, op_d;
   logic [7:0]           arg_q, arg_d;
   logic [OFFSET_W-1:0]  scroll_q, scroll_d;
   logic [SPEED_W-1:0]   speed_q, speed_d;
   logic                 dir_q, dir_d;
   logic                 paused_q, paused_d;
   logic [DIV_W-1:0]     div_q, div_d;

   always_comb begin
      logic                do_step;
      logic                loaded;
      logic [OFFSET_W:0]   spd_w;
      logic [OFFSET_W:0]   sum_w;
      logic [OFFSET_W-1:0] ld_v;
      state_d   = state_q;
      pending_d = pending_q;
      op_d      = op_q;
      arg_d     = arg_q;
      scroll_d  = scroll_q;
      speed_d   = speed_q;
      dir_d     = dir_q;
      paused_d  = paused_q;
      div_d     = div_q;
      do_step   = 1'b0;
      loaded    = 1'b0;
      ld_v      = OFFSET_W'(arg_q);
`ifdef VGA_SCROLL_BOUNCE_EN
      if ({1'b0, ld_v} > (OFFSET_W + 1)'(BOUNCE_MAX)) ld_v = OFFSET_W'(BOUNCE_MAX);
`endif
      tick_d = (vsync_in == VSYNC_POL) && (vs_q != VSYNC_POL);

      if (tick_q) begin
         pending_d = 1'b0;
         if (pending_q) begin
            case (op_q)
               OP_SPEED: speed_d  = arg_q[SPEED_W-1:0];
               OP_DIR:   dir_d    = arg_q[0];
               OP_PAUSE: paused_d = arg_q[0];
               default: begin
                  scroll_d = ld_v;
                  div_d    = '0;
                  loaded   = 1'b1;
               end
            endcase
         end
         // FSM sees the command just applied
         case (state_q)
            ST_IDLE:  if (run_en) state_d = paused_d ? ST_PAUSE : ST_RUN;
            ST_RUN: begin
               if (!run_en)       state_d = ST_IDLE;
               else if (paused_d) state_d = ST_PAUSE;
               else               do_step = ~loaded;
            end
            ST_PAUSE: begin
               if (!run_en)        state_d = ST_IDLE;
               else if (!paused_d) state_d = ST_RUN;
            end
            default:  state_d = ST_IDLE;
         endcase
      end

      spd_w = (OFFSET_W + 1)'(speed_d);
      sum_w = {1'b0, scroll_q} + spd_w;
      if (do_step) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
`ifdef VGA_SCROLL_BOUNCE_EN
            if (dir_d) begin
               if ({1'b0, scroll_q} < spd_w) begin
                  scroll_d = '0;
                  dir_d    = 1'b0;
               end else begin
                  scroll_d = scroll_q - spd_w[OFFSET_W-1:0];
               end
            end else if (sum_w > (OFFSET_W + 1)'(BOUNCE_MAX)) begin
               scroll_d = OFFSET_W'(BOUNCE_MAX);
               dir_d    = 1'b1;
            end else begin
               scroll_d = sum_w[OFFSET_W-1:0];
            end
`else
            scroll_d = dir_d ? (scroll_q - spd_w[OFFSET_W-1:0]) : sum_w[OFFSET_W-1:0];
`endif
         end else begin
            div_d = div_q + 1'b1;
         end
      end

      if (cmd_valid && !pending_q) begin
         pending_d = 1'b1;
         op_d      = cmd_op;
         arg_d     = cmd_arg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         vs_q      <= ~VSYNC_POL;
         tick_q    <= 1'b0;
         pending_q <= 1'b0;
         op_q      <= 2'b00;
         arg_q     <= 8'h00;
         scroll_q  <= '0;
         speed_q   <= SPEED_W'(1);
         dir_q     <= 1'b0;
         paused_q  <= 1'b0;
         div_q     <= '0;
      end else begin
         state_q   <= state_d;
         vs_q      <= vsync_in;
         tick_q    <= tick_d;
         pending_q <= pending_d;
         op_q      <= op_d;
         arg_q     <= arg_d;
         scroll_q  <= scroll_d;
         speed_q   <= speed_d;
         dir_q     <= dir_d;
         paused_q  <= paused_d;
         div_q     <= div_d;
      end
   end

   assign cmd_ready  = ~pending_q;
   assign scroll_x   = scroll_q;
   assign frame_tick = tick_q;
   assign state      = state_q;

endmodule

// File: tb/tb_vga_scroll_sequencer.sv
// Directed bench for vga_scroll_sequencer; a second instance with FRAME_DIV=2 covers the divider.
module tb_vga_scroll_sequencer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vsync_in = 1'b1;
   logic       run_en = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_arg = 8'h00;
   logic       cmd_ready, frame_tick, ready2, tick2;
   logic [9:0] scroll_x, scroll2;
   logic [1:0] state, state2;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   vga_scroll_sequencer u_dut (
      .clk(clk), .rst_n(rst_n), .vsync_in(vsync_in), .run_en(run_en),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
      .scroll_x(scroll_x), .frame_tick(frame_tick), .state(state));

   vga_scroll_sequencer #(.FRAME_DIV(2)) u_div2 (
      .clk(clk), .rst_n(rst_n), .vsync_in(vsync_in), .run_en(run_en),
      .cmd_valid(cmd_valid), .cmd_ready(ready2), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
      .scroll_x(scroll2), .frame_tick(tick2), .state(state2));

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // One vsync pulse; tick must appear exactly one clk after the falling edge, for one cycle.
   task automatic do_frame();
      @(negedge clk) vsync_in = 1'b0;
      @(negedge clk);
      chk("tick_high", int'(frame_tick), 1);
      @(negedge clk) vsync_in = 1'b1;
      chk("tick_low", int'(frame_tick), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg);
      @(negedge clk);
      chk("ready_before_cmd", int'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      @(negedge clk) cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      run_en = 1'b0;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_scroll", int'(scroll_x), 0);
      chk("rst_tick", int'(frame_tick), 0);
      chk("rst_ready", int'(cmd_ready), 1);
      chk("rst_state", int'(state), 0);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_run();
      run_en = 1'b1;
      do_frame();
      chk("run_f1_state", int'(state), 1);
      chk("run_f1_scroll", int'(scroll_x), 0);
      do_frame();
      chk("run_f2_scroll", int'(scroll_x), 1);
      do_frame();
      chk("run_f3_scroll", int'(scroll_x), 2);
   endtask

   task automatic test_speed();
      send_cmd(2'b00, 8'd5);
      chk("speed_ready_low", int'(cmd_ready), 0);
      repeat (4) @(negedge clk);
      chk("speed_ready_held", int'(cmd_ready), 0);
      chk("speed_scroll_midframe", int'(scroll_x), 2);
      do_frame();
      chk("speed_ready_back", int'(cmd_ready), 1);
      chk("speed_f1_scroll", int'(scroll_x), 7);
      do_frame();
      chk("speed_f2_scroll", int'(scroll_x), 12);
   endtask

   task automatic test_wrap();
      int e_dn1, e_dn2;
`ifdef VGA_SCROLL_BOUNCE_EN
      e_dn1 = 0;    e_dn2 = 3;
`else
      e_dn1 = 1023; e_dn2 = 1020;
`endif
      send_cmd(2'b00, 8'd3);
      do_frame();
      chk("wrap_speed3", int'(scroll_x), 15);
      send_cmd(2'b11, 8'd2);
      do_frame();
      chk("wrap_load", int'(scroll_x), 2);
      send_cmd(2'b01, 8'd1);
      do_frame();
      chk("wrap_down1", int'(scroll_x), e_dn1);
      do_frame();
      chk("wrap_down2", int'(scroll_x), e_dn2);
   endtask

   task automatic test_pause();
      do_reset();
      run_en = 1'b1;
      do_frame();
      chk("pause_f1_state2", int'(state2), 1);
      do_frame();
      chk("pause_f2_scroll", int'(scroll_x), 1);
      chk("pause_f2_scroll2", int'(scroll2), 0);
      send_cmd(2'b10, 8'd1);
      do_frame();
      chk("pause_f3_state", int'(state), 2);
      chk("pause_f3_scroll", int'(scroll_x), 1);
      do_frame();
      chk("pause_f4_state2", int'(state2), 2);
      chk("pause_f4_scroll2", int'(scroll2), 0);
      chk("pause_f4_scroll", int'(scroll_x), 1);
      send_cmd(2'b10, 8'd0);
      do_frame();
      chk("pause_f5_state", int'(state), 1);
      chk("pause_f5_scroll", int'(scroll_x), 1);
      chk("pause_f5_scroll2", int'(scroll2), 0);
      do_frame();
      chk("pause_f6_scroll", int'(scroll_x), 2);
      chk("pause_f6_scroll2", int'(scroll2), 1);
   endtask

   task automatic test_tick_cmd();
      @(negedge clk) vsync_in = 1'b0;
      @(negedge clk);
      chk("tc_tick", int'(frame_tick), 1);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_arg = 8'd4;
      @(negedge clk);
      cmd_valid = 1'b0;
      vsync_in = 1'b1;
      chk("tc_old_speed_step", int'(scroll_x), 3);
      chk("tc_pending", int'(cmd_ready), 0);
      repeat (3) @(negedge clk);
      do_frame();
      chk("tc_applied", int'(scroll_x), 7);
      chk("tc_ready", int'(cmd_ready), 1);
   endtask

   task automatic test_reset_mid();
      send_cmd(2'b00, 8'd7);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_scroll", int'(scroll_x), 0);
      chk("mid_rst_state", int'(state), 0);
      chk("mid_rst_ready", int'(cmd_ready), 1);
      chk("mid_rst_tick", int'(frame_tick), 0);
      @(negedge clk) rst_n = 1'b1;
      run_en = 1'b1;
      do_frame();
      chk("mid_f1_state", int'(state), 1);
      chk("mid_f1_scroll", int'(scroll_x), 0);
      do_frame();
      chk("mid_f2_discarded", int'(scroll_x), 1);
   endtask

`ifdef VGA_SCROLL_BOUNCE_EN
   task automatic test_bounce();
      send_cmd(2'b00, 8'd7);
      do_frame();
      chk("bnc_speed7", int'(scroll_x), 8);
      send_cmd(2'b11, 8'd252);
      do_frame();
      chk("bnc_load", int'(scroll_x), 252);
      for (int i = 0; i < 55; i++) do_frame();
      chk("bnc_637", int'(scroll_x), 637);
      send_cmd(2'b00, 8'd4);
      do_frame();
      chk("bnc_clamp_top", int'(scroll_x), 639);
      do_frame();
      chk("bnc_turned", int'(scroll_x), 635);
   endtask
`endif

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_run();
      test_speed();
      test_wrap();
      test_pause();
      test_tick_cmd();
      test_reset_mid();
`ifdef VGA_SCROLL_BOUNCE_EN
      test_bounce();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
